// File: rtl/eth_tx_frame_arbiter.sv
// Round-robin frame arbiter in front of eth_axis_tx: a grant covers header plus whole payload,
// and a payload stall watchdog aborts (tuser=1) and drains a source that stops sending.
module eth_tx_frame_arbiter #(
  parameter int S_COUNT        = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic                   i_clk,
  input  logic                   rst,
  input  logic [S_COUNT-1:0]     s_eth_hdr_valid,
  output logic [S_COUNT-1:0]     s_eth_hdr_ready,
  input  logic [48*S_COUNT-1:0]  s_eth_dest_mac,
  input  logic [48*S_COUNT-1:0]  s_eth_src_mac,
  input  logic [16*S_COUNT-1:0]  s_eth_type,
  input  logic [8*S_COUNT-1:0]   s_eth_payload_axis_tdata,
  input  logic [S_COUNT-1:0]     s_eth_payload_axis_tvalid,
  output logic [S_COUNT-1:0]     s_eth_payload_axis_tready,
  input  logic [S_COUNT-1:0]     s_eth_payload_axis_tlast,
  input  logic [S_COUNT-1:0]     s_eth_payload_axis_tuser,
  output logic                   m_eth_hdr_valid,
  input  logic                   m_eth_hdr_ready,
  output logic [47:0]            m_eth_dest_mac,
  output logic [47:0]            m_eth_src_mac,
  output logic [15:0]            m_eth_type,
  output logic [7:0]             m_eth_payload_axis_tdata,
  output logic                   m_eth_payload_axis_tvalid,
  input  logic                   m_eth_payload_axis_tready,
  output logic                   m_eth_payload_axis_tlast,
  output logic                   m_eth_payload_axis_tuser,
  output logic [S_COUNT-1:0]     o_grant,
  output logic                   o_busy,
  output logic                   o_abort
);

  localparam int GW = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, ABORT, DRAIN} state_t;

  state_t             state;
  logic [GW-1:0]      g;
  logic [GW-1:0]      last_grant;
  logic [S_COUNT-1:0] grant;
  logic [CNT_W-1:0]   wd;
  logic [GW-1:0]      next_g;
  logic               req_found;
  int                 idx;

  // First requester strictly after last_grant, wrapping, so every waiting source gets one turn per rotation.
  always_comb begin
    next_g    = '0;
    req_found = 1'b0;
    idx       = 0;
    for (int k = 1; k <= S_COUNT; k++) begin
      idx = (int'(last_grant) + k) % S_COUNT;
      if (!req_found && s_eth_hdr_valid[GW'(idx)]) begin
        req_found = 1'b1;
        next_g    = GW'(idx);
      end
    end
  end

  // Every channel transfers on a cycle where valid and ready are both high; valid never waits on ready.
  always_comb begin
    s_eth_hdr_ready           = '0;
    s_eth_payload_axis_tready = '0;
    m_eth_hdr_valid           = 1'b0;
    m_eth_dest_mac            = '0;
    m_eth_src_mac             = '0;
    m_eth_type                = '0;
    m_eth_payload_axis_tdata  = '0;
    m_eth_payload_axis_tvalid = 1'b0;
    m_eth_payload_axis_tlast  = 1'b0;
    m_eth_payload_axis_tuser  = 1'b0;
    o_abort                   = 1'b0;
    case (state)
      HDR: begin
        m_eth_hdr_valid    = s_eth_hdr_valid[g];
        m_eth_dest_mac     = s_eth_dest_mac[48*g +: 48];
        m_eth_src_mac      = s_eth_src_mac[48*g +: 48];
        m_eth_type         = s_eth_type[16*g +: 16];
        s_eth_hdr_ready[g] = m_eth_hdr_ready;
      end
      PAYLOAD: begin
        m_eth_payload_axis_tvalid    = s_eth_payload_axis_tvalid[g];
        m_eth_payload_axis_tdata     = s_eth_payload_axis_tdata[8*g +: 8];
        m_eth_payload_axis_tlast     = s_eth_payload_axis_tlast[g];
        m_eth_payload_axis_tuser     = s_eth_payload_axis_tuser[g];
        s_eth_payload_axis_tready[g] = m_eth_payload_axis_tready;
      end
      ABORT: begin
        m_eth_payload_axis_tvalid = 1'b1;
        m_eth_payload_axis_tlast  = 1'b1;
        m_eth_payload_axis_tuser  = 1'b1;
        o_abort                   = m_eth_payload_axis_tready;
      end
      DRAIN: s_eth_payload_axis_tready[g] = 1'b1;
      default: ;
    endcase
  end

  assign o_grant = grant;
  assign o_busy  = (state != IDLE);

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      g          <= '0;
      grant      <= '0;
      last_grant <= GW'(S_COUNT - 1);
      wd         <= '0;
    end else begin
      case (state)
        IDLE: if (req_found) begin
          g     <= next_g;
          grant <= {{(S_COUNT-1){1'b0}}, 1'b1} << next_g;
          state <= HDR;
        end
        HDR: if (s_eth_hdr_valid[g] && m_eth_hdr_ready) begin
          state <= PAYLOAD;
          wd    <= '0;
        end
        PAYLOAD: begin
          if (s_eth_payload_axis_tvalid[g]) begin
            // Only a silent source counts; downstream backpressure never does.
            wd <= '0;
            if (m_eth_payload_axis_tready && s_eth_payload_axis_tlast[g]) begin
              state      <= IDLE;
              last_grant <= g;
              grant      <= '0;
            end
          end else if (WD_EN && wd == WD_LAST) begin
            state <= ABORT;
            wd    <= '0;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        ABORT: if (m_eth_payload_axis_tready) state <= DRAIN;
        DRAIN: if (s_eth_payload_axis_tvalid[g] && s_eth_payload_axis_tlast[g]) begin
          state      <= IDLE;
          last_grant <= g;
          grant      <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/eth_tx_frame_arbiter.md
Name: eth_tx_frame_arbiter

Overview:
- Shares one eth_axis_tx header/payload input between S_COUNT frame sources, for example the loopback path and a local beacon or status generator.
- Arbitration is round-robin, and a grant lasts for a whole frame: the header plus its complete payload.
- A payload stall watchdog catches a granted source that stops sending. It aborts the frame toward eth_axis_tx with tuser=1, discards the rest of that source's frame, and then frees the channel.
- The block sits between the frame sources and eth_axis_tx. It runs on the 125 MHz logic clock.

Parameters:
- S_COUNT, 2: number of requesting sources (2..8).
- TIMEOUT_CYCLES, 1024: consecutive granted-payload cycles with s tvalid low that trigger an abort. 0 disables the watchdog.
- CNT_W, 16: width of the watchdog counter. TIMEOUT_CYCLES must be less than 2^CNT_W.

Ports:
- i_clk  in  1  logic clock
- rst  in  1  asynchronous, active-high reset
- s_eth_hdr_valid  in  S_COUNT  per-source header valid
- s_eth_hdr_ready  out  S_COUNT  per-source header ready
- s_eth_dest_mac  in  48*S_COUNT  flattened; source i occupies [48i+47:48i]
- s_eth_src_mac  in  48*S_COUNT  flattened, same slicing
- s_eth_type  in  16*S_COUNT  flattened
- s_eth_payload_axis_tdata  in  8*S_COUNT  flattened payload data
- s_eth_payload_axis_tvalid  in  S_COUNT  payload valid
- s_eth_payload_axis_tready  out  S_COUNT  payload ready
- s_eth_payload_axis_tlast  in  S_COUNT  payload last
- s_eth_payload_axis_tuser  in  S_COUNT  payload user (bad-frame flag)
- m_eth_hdr_valid  out  1  header valid to eth_axis_tx
- m_eth_hdr_ready  in  1  header ready from eth_axis_tx
- m_eth_dest_mac  out  48  selected destination MAC
- m_eth_src_mac  out  48  selected source MAC
- m_eth_type  out  16  selected EtherType
- m_eth_payload_axis_tdata  out  8  payload data
- m_eth_payload_axis_tvalid  out  1  payload valid
- m_eth_payload_axis_tready  in  1  payload ready
- m_eth_payload_axis_tlast  out  1  payload last
- m_eth_payload_axis_tuser  out  1  payload user
- o_grant  out  S_COUNT  one-hot index of the current owner; 0 in IDLE
- o_busy  out  1  high in any state other than IDLE
- o_abort  out  1  one-cycle pulse on the accepted abort beat

Behaviour:
- States are IDLE, HDR, PAYLOAD, ABORT and DRAIN.
- Reset, asynchronous:
  - state=IDLE, grant register=0, last_grant=S_COUNT-1, watchdog=0.
  - Every output is 0, including all ready outputs, m_eth_hdr_valid, m_eth_payload_axis_tvalid, o_grant, o_busy and o_abort.
  - A reset in the middle of a frame abandons it immediately; no tlast is emitted.
- IDLE:
  - All s_*_ready outputs are 0 and both m valids are 0.
  - If any s_eth_hdr_valid is high, grant goes to the first requesting index after last_grant, wrapping modulo S_COUNT.
  - The grant is registered and the state moves to HDR the next cycle. This costs 1 cycle of arbitration latency.
- HDR:
  - m_eth_hdr_valid = s_eth_hdr_valid[g], and the header fields of source g drive the m header fields combinationally.
  - s_eth_hdr_ready[g] = m_eth_hdr_ready; every other source's ready is 0.
  - On a handshake the state moves to PAYLOAD and the watchdog clears.
- PAYLOAD:
  - Payload channel g is passed through combinationally: m valid/data/last/user come from source g, and s_tready[g] = m_eth_payload_axis_tready.
  - A beat is accepted when valid and ready are both high.
  - An accepted beat with tlast=1 moves the state to IDLE and sets last_grant=g.
- Watchdog, PAYLOAD only:
  - Increments on each cycle where s tvalid[g]=0 and clears on any cycle where it is 1.
  - When TIMEOUT_CYCLES is nonzero and the count equals TIMEOUT_CYCLES-1 with tvalid still 0, the state moves to ABORT.
  - Abort therefore occurs after exactly TIMEOUT_CYCLES idle cycles.
  - A stall caused by m tready=0 while tvalid=1 never counts.
- ABORT:
  - m tvalid=1, tdata=0x00, tlast=1, tuser=1; s_tready[g]=0.
  - Holds until m_eth_payload_axis_tready is high.
  - On that accept, o_abort pulses and the state moves to DRAIN.
- DRAIN:
  - s_tready[g]=1 and m tvalid=0; source g's beats are discarded.
  - The state moves to IDLE on the accepted tlast beat, and last_grant=g.
  - If no tlast ever arrives, the block stays in DRAIN by design; it has no second timeout.
- Arbitration:
  - Non-owners always see ready=0.
  - Requests arriving during a frame are held off, not lost; valid stays high per AXI.
  - If all S_COUNT sources are waiting, each is served once per rotation.
- A 1-beat frame (tlast on the first beat) is legal: HDR, one beat in PAYLOAD, then IDLE.
- Throughput: one payload beat per cycle. There is a minimum of 2 idle cycles between frames (IDLE plus the HDR handshake).

Test Plan:
- Single request: source 0 sends header (dest FF:FF:FF:FF:FF:FF, type 0x88B5) and 4 payload bytes 0x01..0x04 with m ready always 1.
  - o_grant=01; header appears 1 cycle after the request.
  - The 4 bytes appear in order with tlast on 0x04, then o_busy falls.
- Contention: sources 0 and 1 request in the same cycle from reset.
  - Source 0 is served first (last_grant reset value is S_COUNT-1), then source 1.
  - A repeated simultaneous request then serves 0 before 1 again, confirming rotation.
- Backpressure: m tready toggles 1,0,1,0 during a 16-byte frame.
  - All 16 bytes arrive with no duplication or loss.
  - The watchdog never fires, even with TIMEOUT_CYCLES=4.
- Timeout with TIMEOUT_CYCLES=8: source 1 sends 3 bytes, then holds tvalid low.
  - Exactly 8 cycles later m emits 0x00 with tlast=1 and tuser=1, and o_abort pulses for 1 cycle.
  - The 5 bytes source 1 sends afterwards are sunk with tready=1 and none appear on m.
  - The next grant goes to source 0.
- Mid-frame reset: rst asserts during a PAYLOAD beat.
  - All outputs go to 0 asynchronously in the same cycle.
  - After release, a new frame from source 1 is granted normally.
